// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its wide-operand sequencer.
package alu_pkg;

    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OPT_NOP = 3'd0;
    localparam logic [OPW-1:0] OPT_ADD = 3'd1;
    localparam logic [OPW-1:0] OPT_SUB = 3'd2;
    localparam logic [OPW-1:0] OPT_AND = 3'd3;
    localparam logic [OPW-1:0] OPT_OR  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Opcodes the ALU actually implements
    function automatic logic op_legal(input logic [OPW-1:0] op);
        return (op == OPT_ADD) || (op == OPT_SUB) || (op == OPT_AND) || (op == OPT_OR);
    endfunction

    // Opcodes whose carry/borrow chains between limbs
    function automatic logic op_arith(input logic [OPW-1:0] op);
        return (op == OPT_ADD) || (op == OPT_SUB);
    endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// Drives the combinational 8-bit ALU one limb per cycle (LSB first) to
// execute a WORDS x 8-bit operation, chaining carry/borrow between limbs.
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OPW-1:0]        req_op,
    input  logic [DW*WORDS-1:0]   req_a,
    input  logic [DW*WORDS-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW*WORDS-1:0]   rsp_s,
    output logic                  rsp_zero,
    output logic                  rsp_co,
    output logic                  rsp_err,
    output logic [OPW-1:0]        alu_opt,
    output logic [DW-1:0]         alu_numa,
    output logic [DW-1:0]         alu_numb,
    output logic [DW-1:0]         alu_ci,
    input  logic [DW-1:0]         alu_s,
    input  logic                  alu_zero,
    input  logic                  alu_co
);

    localparam int unsigned WW = DW * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [WW-1:0]   a_q, a_d;
    logic [WW-1:0]   b_q, b_d;
    logic [WW-1:0]   res_q, res_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            zacc_q, zacc_d;

    logic            req_ready_d;
    logic            rsp_valid_d;
    logic [WW-1:0]   rsp_s_d;
    logic            rsp_zero_d;
    logic            rsp_co_d;
    logic            rsp_err_d;
    logic [OPW-1:0]  alu_opt_d;
    logic [DW-1:0]   alu_numa_d;
    logic [DW-1:0]   alu_numb_d;
    logic [DW-1:0]   alu_ci_d;

    logic [WW-1:0]   res_n;
    logic [IW-1:0]   idx_nx;
    logic            carry_n;
    logic            zacc_n;
    logic            last;

    // State and registered outputs; synchronous reset discards any work in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OPT_NOP;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            zacc_q    <= 1'b1;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_s     <= '0;
            rsp_zero  <= 1'b0;
            rsp_co    <= 1'b0;
            rsp_err   <= 1'b0;
            alu_opt   <= OPT_NOP;
            alu_numa  <= '0;
            alu_numb  <= '0;
            alu_ci    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            zacc_q    <= zacc_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_s     <= rsp_s_d;
            rsp_zero  <= rsp_zero_d;
            rsp_co    <= rsp_co_d;
            rsp_err   <= rsp_err_d;
            alu_opt   <= alu_opt_d;
            alu_numa  <= alu_numa_d;
            alu_numb  <= alu_numb_d;
            alu_ci    <= alu_ci_d;
        end
    end

    // Next state; ALU drive for the following limb is precomputed so it is registered
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        idx_d       = idx_q;
        zacc_d      = zacc_q;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_s_d     = rsp_s;
        rsp_zero_d  = rsp_zero;
        rsp_co_d    = rsp_co;
        rsp_err_d   = rsp_err;
        alu_opt_d   = OPT_NOP;
        alu_numa_d  = '0;
        alu_numb_d  = '0;
        alu_ci_d    = '0;

        // Result of the limb currently presented to the ALU
        res_n                   = res_q;
        res_n[idx_q*DW +: DW]   = alu_s;
        idx_nx                  = idx_q + IW'(1);
        carry_n                 = op_arith(op_q) ? alu_co : 1'b0;
        zacc_n                  = zacc_q & alu_zero;
        last                    = (idx_q == IW'(WORDS - 1));

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d        = req_op;
                    a_d         = req_a;
                    b_d         = req_b;
                    res_d       = '0;
                    idx_d       = '0;
                    zacc_d      = 1'b1;
                    req_ready_d = 1'b0;
                    if (op_legal(req_op)) begin
                        state_d    = ST_ISSUE;
                        alu_opt_d  = req_op;
                        alu_numa_d = req_a[DW-1:0];
                        alu_numb_d = req_b[DW-1:0];
                        alu_ci_d   = '0;
                    end else begin
                        state_d    = ST_RESP;
                        rsp_s_d    = '0;
                        rsp_zero_d = 1'b1;
                        rsp_co_d   = 1'b0;
                        rsp_err_d  = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                res_d  = res_n;
                zacc_d = zacc_n;
                if (last) begin
                    state_d    = ST_RESP;
                    rsp_s_d    = res_n;
                    rsp_zero_d = zacc_n;
                    rsp_co_d   = carry_n;
                    rsp_err_d  = 1'b0;
                end else begin
                    idx_d      = idx_nx;
                    alu_opt_d  = op_q;
                    alu_numa_d = a_q[idx_nx*DW +: DW];
                    alu_numb_d = b_q[idx_nx*DW +: DW];
                    alu_ci_d   = {7'b0, carry_n};
                end
            end

            ST_RESP: begin
                // Result registers settle on entry; valid rises one cycle later
                if (!rsp_valid) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench: sequencer (WORDS=2) wired to a behavioural 8-bit ALU.
module tb_alu_wide_sequencer;
    import alu_pkg::*;

    localparam int unsigned WORDS = 2;
    localparam int unsigned WW    = 8 * WORDS;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_op;
    logic [WW-1:0]  req_a;
    logic [WW-1:0]  req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [WW-1:0]  rsp_s;
    logic           rsp_zero;
    logic           rsp_co;
    logic           rsp_err;
    logic [2:0]     alu_opt;
    logic [7:0]     alu_numa;
    logic [7:0]     alu_numb;
    logic [7:0]     alu_ci;
    logic [7:0]     alu_s;
    logic           alu_zero;
    logic           alu_co;
    logic [8:0]     sum9;

    int tests;
    int fails;

    alu_wide_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_zero  (rsp_zero),
        .rsp_co    (rsp_co),
        .rsp_err   (rsp_err),
        .alu_opt   (alu_opt),
        .alu_numa  (alu_numa),
        .alu_numb  (alu_numb),
        .alu_ci    (alu_ci),
        .alu_s     (alu_s),
        .alu_zero  (alu_zero),
        .alu_co    (alu_co)
    );

    // Behavioural combinational 8-bit ALU
    always_comb begin
        sum9   = 9'd0;
        alu_co = 1'b0;
        case (alu_opt)
            3'd1: begin
                sum9   = {1'b0, alu_numa} + {1'b0, alu_numb} + {1'b0, alu_ci};
                alu_co = sum9[8];
            end
            3'd2: begin
                sum9   = {1'b0, alu_numa} - {1'b0, alu_numb} - {1'b0, alu_ci};
                alu_co = sum9[8];
            end
            3'd3: sum9 = {1'b0, alu_numa & alu_numb};
            3'd4: sum9 = {1'b0, alu_numa | alu_numb};
            default: sum9 = 9'd0;
        endcase
        alu_s    = sum9[7:0];
        alu_zero = (sum9[7:0] == 8'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request; returns #1 after the accepting edge
    task automatic do_req(input logic [2:0] op, input logic [WW-1:0] a, input logic [WW-1:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
    endtask

    // Wait up to a bounded number of edges for rsp_valid
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        tests++; if ({rsp_s, rsp_zero, rsp_co, rsp_err} !== '0) begin fails++;
            $display("FAIL reset_rsp got s=%h z=%b co=%b err=%b exp all 0", rsp_s, rsp_zero, rsp_co, rsp_err); end
        tests++; if ({alu_opt, alu_numa, alu_numb, alu_ci} !== '0) begin fails++;
            $display("FAIL reset_alu got opt=%0d a=%h b=%h ci=%h exp all 0", alu_opt, alu_numa, alu_numb, alu_ci); end
    endtask

    task automatic test_add_carry();
        do_req(3'd1, 16'h00FF, 16'h0001);
        // after accept edge 0: limb 0 presented
        tests++; if ({alu_opt, alu_numa, alu_numb, alu_ci} !== {3'd1, 8'hFF, 8'h01, 8'h00}) begin fails++;
            $display("FAIL add_limb0 got opt=%0d a=%h b=%h ci=%h exp 1 ff 01 00", alu_opt, alu_numa, alu_numb, alu_ci); end
        step();
        tests++; if ({alu_opt, alu_numa, alu_numb, alu_ci} !== {3'd1, 8'h00, 8'h00, 8'h01}) begin fails++;
            $display("FAIL add_limb1 got opt=%0d a=%h b=%h ci=%h exp 1 00 00 01", alu_opt, alu_numa, alu_numb, alu_ci); end
        step();
        tests++; if (rsp_valid !== 1'b0 || alu_opt !== 3'd0) begin fails++;
            $display("FAIL add_edge2 got valid=%b opt=%0d exp 0 0", rsp_valid, alu_opt); end
        step();
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL add_latency got valid=%b at edge 3 exp=1", rsp_valid); end
        tests++; if ({rsp_s, rsp_zero, rsp_co, rsp_err} !== {16'h0100, 3'b000}) begin fails++;
            $display("FAIL add_result got s=%h z=%b co=%b err=%b exp 0100 0 0 0", rsp_s, rsp_zero, rsp_co, rsp_err); end
        handshake();
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++;
            $display("FAIL add_release got valid=%b ready=%b exp 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_wrap();
        int n;
        do_req(3'd2, 16'h0000, 16'h0001);
        wait_rsp(n);
        tests++; if (rsp_valid !== 1'b1 || {rsp_s, rsp_zero, rsp_co, rsp_err} !== {16'hFFFF, 3'b010}) begin fails++;
            $display("FAIL sub_borrow got v=%b s=%h z=%b co=%b err=%b exp 1 ffff 0 1 0", rsp_valid, rsp_s, rsp_zero, rsp_co, rsp_err); end
        handshake();
        do_req(3'd1, 16'hFFFF, 16'h0001);
        wait_rsp(n);
        tests++; if (rsp_valid !== 1'b1 || {rsp_s, rsp_zero, rsp_co, rsp_err} !== {16'h0000, 3'b110}) begin fails++;
            $display("FAIL add_overflow got v=%b s=%h z=%b co=%b err=%b exp 1 0000 1 1 0", rsp_valid, rsp_s, rsp_zero, rsp_co, rsp_err); end
        handshake();
    endtask

    task automatic test_logic();
        int n;
        do_req(3'd3, 16'h5555, 16'hAAAA);
        wait_rsp(n);
        tests++; if (rsp_valid !== 1'b1 || {rsp_s, rsp_zero, rsp_co, rsp_err} !== {16'h0000, 3'b100}) begin fails++;
            $display("FAIL and_op got v=%b s=%h z=%b co=%b err=%b exp 1 0000 1 0 0", rsp_valid, rsp_s, rsp_zero, rsp_co, rsp_err); end
        handshake();
        do_req(3'd4, 16'h5555, 16'hAAAA);
        wait_rsp(n);
        tests++; if (rsp_valid !== 1'b1 || {rsp_s, rsp_zero, rsp_co, rsp_err} !== {16'hFFFF, 3'b000}) begin fails++;
            $display("FAIL or_op got v=%b s=%h z=%b co=%b err=%b exp 1 ffff 0 0 0", rsp_valid, rsp_s, rsp_zero, rsp_co, rsp_err); end
        handshake();
    endtask

    task automatic test_backpressure();
        int n;
        do_req(3'd1, 16'h1234, 16'h1111);
        wait_rsp(n);
        // hold off the consumer while a new request waits
        req_valid = 1'b1;
        req_op    = 3'd2;
        req_a     = 16'h0010;
        req_b     = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            tests++; if (rsp_valid !== 1'b1 || rsp_s !== 16'h2345 || rsp_co !== 1'b0 || req_ready !== 1'b0) begin fails++;
                $display("FAIL bp_hold[%0d] got v=%b s=%h co=%b rdy=%b exp 1 2345 0 0", i, rsp_valid, rsp_s, rsp_co, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_opt !== 3'd0) begin fails++;
            $display("FAIL bp_no_reaccept got v=%b rdy=%b opt=%0d exp 0 1 0", rsp_valid, req_ready, alu_opt); end
        step();
        req_valid = 1'b0;
        tests++; if (req_ready !== 1'b0 || alu_opt !== 3'd2 || alu_numa !== 8'h10) begin fails++;
            $display("FAIL bp_accept_next got rdy=%b opt=%0d a=%h exp 0 2 10", req_ready, alu_opt, alu_numa); end
        wait_rsp(n);
        tests++; if (rsp_valid !== 1'b1 || {rsp_s, rsp_zero, rsp_co} !== {16'h000F, 2'b00}) begin fails++;
            $display("FAIL bp_second got v=%b s=%h z=%b co=%b exp 1 000f 0 0", rsp_valid, rsp_s, rsp_zero, rsp_co); end
        handshake();
    endtask

    task automatic test_illegal();
        do_req(3'd6, 16'h1234, 16'h5678);
        tests++; if (rsp_valid !== 1'b0 || alu_opt !== 3'd0 || req_ready !== 1'b0) begin fails++;
            $display("FAIL ill_edge0 got v=%b opt=%0d rdy=%b exp 0 0 0", rsp_valid, alu_opt, req_ready); end
        step();
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL ill_latency got valid=%b at edge 1 exp=1", rsp_valid); end
        tests++; if ({rsp_s, rsp_zero, rsp_co, rsp_err} !== {16'h0000, 3'b101} || alu_opt !== 3'd0) begin fails++;
            $display("FAIL ill_result got s=%h z=%b co=%b err=%b opt=%0d exp 0000 1 0 1 0", rsp_s, rsp_zero, rsp_co, rsp_err, alu_opt); end
        handshake();
        tests++; if (rsp_valid !== 1'b0 || alu_opt !== 3'd0) begin fails++;
            $display("FAIL ill_release got v=%b opt=%0d exp 0 0", rsp_valid, alu_opt); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_req(3'd1, 16'h00FF, 16'h00FF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_opt !== 3'd0) begin fails++;
            $display("FAIL rst_mid got v=%b rdy=%b opt=%0d exp 0 1 0", rsp_valid, req_ready, alu_opt); end
        for (int i = 0; i < 4; i++) step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_stale got valid=%b exp=0", rsp_valid); end
        do_req(3'd1, 16'h0003, 16'h0005);
        wait_rsp(n);
        tests++; if (rsp_valid !== 1'b1 || n !== 3 || {rsp_s, rsp_zero, rsp_co, rsp_err} !== {16'h0008, 3'b000}) begin fails++;
            $display("FAIL rst_mid_add got v=%b edges=%0d s=%h z=%b co=%b err=%b exp 1 3 0008 0 0 0", rsp_valid, n, rsp_s, rsp_zero, rsp_co, rsp_err); end
        handshake();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_add_carry();
        test_wrap();
        test_logic();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
